register_sequencer: RTL and testbench

//   Command-driven controller that sequences the strobes of one general-purpose register
//   (cl/ld/inc/dec/sr/ir/sl/il/in).

---
 rtl/register_sequencer.sv | 150 +++++++++++++++
 tb/tb_register_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_sequencer.sv
// register_sequencer: command-driven strobe sequencer for one general-purpose register.
// Define REGISTER_SEQUENCER_ROTATE_EN to enable op 7 (ROR); otherwise op 7 behaves as NOP.
module register_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_cnt,
    input  logic                  cmd_fill,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] reg_out,
    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_sl,
    output logic                  reg_ir,
    output logic                  reg_il,
    output logic [DATA_WIDTH-1:0] reg_in,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    logic [1:0]            state;
    logic [2:0]            op;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  fill;
    logic [DATA_WIDTH-1:0] data;
    logic                  counted_op;
    logic                  run_active;
    logic                  unused_reg_out;

    // Ops that repeat cmd_cnt times; a disabled ROR falls through to the NOP path.
    always_comb begin
        counted_op = 1'b0;
        case (cmd_op)
            OP_INC, OP_DEC, OP_SHR, OP_SHL: counted_op = 1'b1;
`ifdef REGISTER_SEQUENCER_ROTATE_EN
            OP_ROR: counted_op = 1'b1;
`endif
            default: counted_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_NOP;
            remaining <= '0;
            fill      <= 1'b0;
            data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op   <= cmd_op;
                        fill <= cmd_fill;
                        data <= cmd_data;
                        if (cmd_op == OP_CLR || cmd_op == OP_LOAD) begin
                            remaining <= CNT_WIDTH'(1);
                            state     <= RUN;
                        end else if (counted_op && cmd_cnt != '0) begin
                            remaining <= cmd_cnt;
                            state     <= RUN;
                        end else begin
                            remaining <= '0;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (remaining == CNT_WIDTH'(1)) begin
                        state <= DONE;
                    end else begin
                        remaining <= remaining - CNT_WIDTH'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes come only from latched state; abort suppresses them in the same cycle.
    assign run_active = (state == RUN) && !abort;

    always_comb begin
        reg_cl  = 1'b0;
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_dec = 1'b0;
        reg_sr  = 1'b0;
        reg_sl  = 1'b0;
        reg_ir  = 1'b0;
        reg_il  = 1'b0;
        if (run_active) begin
            case (op)
                OP_CLR:  reg_cl  = 1'b1;
                OP_LOAD: reg_ld  = 1'b1;
                OP_INC:  reg_inc = 1'b1;
                OP_DEC:  reg_dec = 1'b1;
                OP_SHR: begin
                    reg_sr = 1'b1;
                    reg_ir = fill;
                end
                OP_SHL: begin
                    reg_sl = 1'b1;
                    reg_il = fill;
                end
`ifdef REGISTER_SEQUENCER_ROTATE_EN
                OP_ROR: begin
                    reg_sr = 1'b1;
                    reg_ir = reg_out[0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign reg_in    = data;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cmd_ready = (state == IDLE);

    // reg_out is only partly (or not at all) consumed depending on the build.
    assign unused_reg_out = ^reg_out;

endmodule

// File: tb/tb_register_sequencer.sv
// tb_register_sequencer: drives register_sequencer into a behavioural register and checks
// strobe traces, done timing and final register values against an arithmetic model.
module tb_register_sequencer;

    localparam int W = 16;
`ifdef REGISTER_SEQUENCER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [4:0]    cmd_cnt;
    logic          cmd_fill;
    logic [W-1:0]  cmd_data;
    logic          abort;
    logic [W-1:0]  reg_q;
    logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
    logic [W-1:0]  reg_in;
    logic          busy;
    logic          done;

    int pass_count  = 0;
    int check_count = 0;

    register_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
        .abort(abort), .reg_out(reg_q),
        .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il),
        .reg_in(reg_in), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The controlled register, sharing clk/rst_n with the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       reg_q <= '0;
        else if (reg_cl)  reg_q <= '0;
        else if (reg_ld)  reg_q <= reg_in;
        else if (reg_inc) reg_q <= reg_q + 1'b1;
        else if (reg_dec) reg_q <= reg_q - 1'b1;
        else if (reg_sr)  reg_q <= {reg_ir, reg_q[W-1:1]};
        else if (reg_sl)  reg_q <= {reg_q[W-2:0], reg_il};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Number of strobe cycles a command should produce.
    function automatic int model_cycles(input logic [2:0] op, input int cnt);
        case (op)
            3'd1, 3'd2:             return 1;
            3'd3, 3'd4, 3'd5, 3'd6: return cnt;
            3'd7:                   return ROT_EN ? cnt : 0;
            default:                return 0;
        endcase
    endfunction

    // Strobe vector {cl,ld,inc,dec,sr,sl} expected in each strobe cycle.
    function automatic logic [5:0] model_vec(input logic [2:0] op);
        case (op)
            3'd1:    return 6'b100000;
            3'd2:    return 6'b010000;
            3'd3:    return 6'b001000;
            3'd4:    return 6'b000100;
            3'd5:    return 6'b000010;
            3'd6:    return 6'b000001;
            3'd7:    return ROT_EN ? 6'b000010 : 6'b000000;
            default: return 6'b000000;
        endcase
    endfunction

    // Register value after applying n effective repetitions of op to start value s.
    function automatic logic [W-1:0] model_value(input logic [2:0] op, input int n,
                                                 input logic fill, input logic [W-1:0] d,
                                                 input logic [W-1:0] s);
        logic [W-1:0] ones;
        logic [2*W-1:0] dbl;
        ones = '1;
        if (n == 0) return s;
        case (op)
            3'd1: return '0;
            3'd2: return d;
            3'd3: return W'((int'(s) + n) & 32'hFFFF);
            3'd4: return W'((int'(s) - n) & 32'hFFFF);
            3'd5: begin
                if (n >= W) return {W{fill}};
                return (s >> n) | (fill ? ~(ones >> n) : '0);
            end
            3'd6: begin
                if (n >= W) return {W{fill}};
                return (s << n) | (fill ? ~(ones << n) : '0);
            end
            3'd7: begin
                if (!ROT_EN) return s;
                dbl = {s, s} >> (n % W);
                return dbl[W-1:0];
            end
            default: return s;
        endcase
    endfunction

    // Issue one command, follow it cycle by cycle, and check trace, timing and result.
    task automatic applyStimulus(input logic [2:0] op, input int cnt, input logic fill,
                                 input logic [W-1:0] d, input int abort_cycle,
                                 input string name);
        int guard;
        int n_run;
        int n_eff;
        int done_cycle;
        int bad;
        bit aborted;
        logic [5:0] vec;
        logic [5:0] exp_vec;
        logic exp_ir;
        logic exp_il;
        logic [W-1:0] start;
        logic [W-1:0] expect_val;
        bit strobe_cycle;

        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, " ready_before"}, {31'd0, cmd_ready}, 32'd1);

        start = reg_q;
        n_run = model_cycles(op, cnt);
        n_eff = (abort_cycle > 0 && abort_cycle <= n_run) ? abort_cycle - 1 : n_run;
        expect_val = model_value(op, (op == 3'd1 || op == 3'd2) ? n_eff : n_eff, fill, d, start);

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = 5'(cnt);
        cmd_fill  = fill;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_cnt   = 5'($urandom);
        cmd_fill  = 1'($urandom);
        cmd_data  = W'($urandom);

        done_cycle = 0;
        bad = 0;
        aborted = 1'b0;
        for (int k = 1; k <= n_run + 3; k++) begin
            if (k == abort_cycle) abort = 1'b1;
            @(negedge clk);
            strobe_cycle = (k <= n_run) && (k != abort_cycle);
            exp_vec = strobe_cycle ? model_vec(op) : 6'b0;
            exp_ir = 1'b0;
            exp_il = 1'b0;
            if (strobe_cycle && op == 3'd5) exp_ir = fill;
            if (strobe_cycle && op == 3'd7 && ROT_EN) exp_ir = reg_q[0];
            if (strobe_cycle && op == 3'd6) exp_il = fill;
            vec = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
            if (vec !== exp_vec || reg_ir !== exp_ir || reg_il !== exp_il) bad++;
            if (reg_in !== d) bad++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) bad++;
            if (done) begin
                done_cycle = k;
                break;
            end
            if (k == abort_cycle) begin
                @(posedge clk);
                #1;
                abort = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        checkOutput({name, " trace"}, bad, 0);
        if (aborted)
            checkOutput({name, " abort_no_done"}, done_cycle, 0);
        else
            checkOutput({name, " done_cycle"}, done_cycle, n_run + 1);

        @(negedge clk);
        checkOutput({name, " ready_after"}, {30'd0, busy, cmd_ready}, 32'd1);
        checkOutput({name, " value"}, {16'd0, reg_q}, {16'd0, expect_val});
    endtask

    typedef struct {
        logic [2:0]   op;
        int           cnt;
        logic         fill;
        logic [W-1:0] data;
        int           abort_cycle;
        logic [W-1:0] exp_val;
        string        name;
    } vector_t;

    vector_t vectors[$];
    int seen_early;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_cnt   = 5'd0;
        cmd_fill  = 1'b0;
        cmd_data  = '0;
        abort     = 1'b0;

        #1;
        checkOutput("reset strobes", {24'd0, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il}, 32'd0);
        checkOutput("reset ready/busy/done", {29'd0, cmd_ready, busy, done}, 32'b100);
        checkOutput("reset reg_in", {16'd0, reg_in}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vectors.push_back('{3'd2, 0,  1'b0, 16'hA5A5, 0, 16'hA5A5, "load_a5a5"});
        vectors.push_back('{3'd3, 3,  1'b0, 16'h0000, 0, 16'hA5A8, "inc3"});
        vectors.push_back('{3'd2, 0,  1'b0, 16'hFFFE, 0, 16'hFFFE, "load_fffe"});
        vectors.push_back('{3'd3, 3,  1'b0, 16'h0000, 0, 16'h0001, "inc3_wrap"});
        vectors.push_back('{3'd4, 2,  1'b0, 16'h0000, 0, 16'hFFFF, "dec2_wrap"});
        vectors.push_back('{3'd2, 0,  1'b0, 16'h8001, 0, 16'h8001, "load_8001"});
        vectors.push_back('{3'd6, 4,  1'b1, 16'h0000, 0, 16'h001F, "shl4_fill1"});
        vectors.push_back('{3'd5, 20, 1'b0, 16'h0000, 0, 16'h0000, "shr20_fill0"});
        vectors.push_back('{3'd2, 0,  1'b0, 16'h1234, 0, 16'h1234, "load_1234"});
        vectors.push_back('{3'd3, 0,  1'b0, 16'h0000, 0, 16'h1234, "inc0"});
        vectors.push_back('{3'd1, 7,  1'b0, 16'hBEEF, 0, 16'h0000, "clr"});
        vectors.push_back('{3'd5, 3,  1'b1, 16'h0000, 0, 16'hE000, "shr3_fill1"});
        vectors.push_back('{3'd0, 5,  1'b0, 16'h0000, 0, 16'hE000, "nop"});
        vectors.push_back('{3'd2, 0,  1'b0, 16'h0000, 0, 16'h0000, "load_0"});
        vectors.push_back('{3'd3, 8,  1'b0, 16'h0000, 3, 16'h0002, "inc8_abort3"});
        vectors.push_back('{3'd2, 0,  1'b0, 16'h0003, 0, 16'h0003, "load_3"});
        vectors.push_back('{3'd7, 1,  1'b0, 16'h0000, 0, ROT_EN ? 16'h8001 : 16'h0003, "ror1"});

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].op, vectors[i].cnt, vectors[i].fill, vectors[i].data,
                          vectors[i].abort_cycle, vectors[i].name);
            checkOutput({vectors[i].name, " table"}, {16'd0, reg_q}, {16'd0, vectors[i].exp_val});
        end

        // Reset in the middle of a long INC.
        applyStimulus(3'd2, 0, 1'b0, 16'h0040, 0, "rst_pre_load");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_cnt   = 5'd10;
        cmd_data  = 16'h00FF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid strobes", {24'd0, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il}, 32'd0);
        checkOutput("rst_mid ready/busy/done", {29'd0, cmd_ready, busy, done}, 32'b100);
        checkOutput("rst_mid reg_in", {16'd0, reg_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'd2, 0, 1'b0, 16'h5A5A, 0, "post_rst_load");

        // Back-to-back: cmd_valid held high; the LOAD must wait for cmd_ready.
        applyStimulus(3'd2, 0, 1'b0, 16'h0010, 0, "b2b_pre_load");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_cnt   = 5'd2;
        cmd_data  = 16'h1111;
        @(posedge clk);
        #1;
        cmd_op    = 3'd2;
        cmd_cnt   = 5'd0;
        cmd_data  = 16'h7777;
        seen_early = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (cmd_ready || reg_ld || reg_in !== 16'h1111) seen_early++;
        end
        checkOutput("b2b held_off", seen_early, 0);
        @(negedge clk);
        checkOutput("b2b ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("b2b inc_result", {16'd0, reg_q}, 32'h0012);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b ld_strobe", {31'd0, reg_ld}, 32'd1);
        checkOutput("b2b reg_in", {16'd0, reg_in}, 32'h7777);
        @(negedge clk);
        checkOutput("b2b done", {31'd0, done}, 32'd1);
        checkOutput("b2b value", {16'd0, reg_q}, 32'h7777);

        // Randomized commands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] r_op;
            int r_cnt;
            int r_abort;
            r_op  = 3'($urandom_range(0, 7));
            r_cnt = (i % 4 == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 9));
            r_abort = 0;
            if (r_op >= 3'd3 && r_op <= 3'd6 && r_cnt > 0 && $urandom_range(0, 4) == 0)
                r_abort = int'($urandom_range(1, r_cnt));
            applyStimulus(r_op, r_cnt, 1'($urandom), W'($urandom), r_abort, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
